// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 64-bit accumulator, one operand register and one counter.
module ex_muldiv #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   localparam logic [5:0]      LAST_ITER = 6'(ITER - 1);
   localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [4:0]      rd_q, rd_d;
   logic [4:0]      rd_out_q, rd_out_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            neg_a_q, neg_a_d;
   logic            neg_b_q, neg_b_d;
   logic            done_q, done_d;

   // Start-time decode of the incoming instruction
   logic            sign_a, sign_b;
   logic            in_neg_a, in_neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;

   always_comb begin
      sign_a = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
               (funct3_i == F_DIV)  || (funct3_i == F_REM);
      sign_b = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
      in_neg_a = sign_a & rs1_i[XLEN-1];
      in_neg_b = sign_b & rs2_i[XLEN-1];
      mag_a = in_neg_a ? (~rs1_i + 1'b1) : rs1_i;
      mag_b = in_neg_b ? (~rs2_i + 1'b1) : rs2_i;

      div_zero = funct3_i[2] && (rs2_i == '0);
      div_ovf  = funct3_i[2] && !funct3_i[0] && (rs1_i == MIN_INT) && (rs2_i == '1);
      special  = div_zero || div_ovf;

      if (div_zero) begin
         special_res = funct3_i[1] ? rs1_i : '1;
      end else begin
         special_res = funct3_i[1] ? '0 : MIN_INT;
      end
   end

   // One datapath iteration, chosen by operation class
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     shifted;
   logic [XLEN+1:0]   diff_full;
   logic              q_bit;
   logic [XLEN-1:0]   hi_nx, lo_nx;

   always_comb begin
      add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      shifted   = {hi_q, lo_q[XLEN-1]};
      diff_full = {1'b0, shifted} - {2'b00, opb_q};
      q_bit     = ~|diff_full[XLEN+1:XLEN];

      if (funct3_q[2]) begin
         hi_nx = q_bit ? diff_full[XLEN-1:0] : shifted[XLEN-1:0];
         lo_nx = {lo_q[XLEN-2:0], q_bit};
      end else begin
         hi_nx = add_sum[XLEN:1];
         lo_nx = {add_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign correction applied to the final iteration's value
   logic [2*XLEN-1:0] prod_raw, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      prod_raw = {hi_nx, lo_nx};
      prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw + 1'b1) : prod_raw;
      quo_fix  = (neg_a_q ^ neg_b_q) ? (~lo_nx + 1'b1) : lo_nx;
      rem_fix  = neg_a_q ? (~hi_nx + 1'b1) : hi_nx;

      case (funct3_q)
         F_MUL:                      final_res = prod_fix[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:              final_res = quo_fix;
         F_REM, F_REMU:              final_res = rem_fix;
         default:                    final_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      rd_out_d = rd_out_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               funct3_d = funct3_i;
               rd_d     = rd_i;
               neg_a_d  = in_neg_a;
               neg_b_d  = in_neg_b;
               cnt_d    = '0;
               if (special) begin
                  state_d  = S_DONE;
                  result_d = special_res;
                  rd_out_d = rd_i;
                  done_d   = 1'b1;
               end else begin
                  state_d = S_CALC;
                  hi_d    = '0;
                  lo_d    = mag_a;
                  opb_d   = mag_b;
               end
            end
         end
         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               hi_d  = hi_nx;
               lo_d  = lo_nx;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) begin
                  state_d  = S_DONE;
                  result_d = final_res;
                  rd_out_d = rd_q;
                  done_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         rd_out_q <= rd_out_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         done_q   <= done_d;
      end
   end

   // A flush landing on the DONE cycle suppresses the handoff
   assign done_o   = done_q & ~flush_i;
   assign busy_o   = (state_q != S_IDLE);
   assign stall_o  = ~rst & (((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_CALC));
   assign result_o = result_q;
   assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: each task drives one scenario and checks results inline.
module tb_ex_muldiv;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int errors = 0;
   int checks = 0;

   ex_muldiv #(.XLEN(32), .ITER(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .rd_i     (rd_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one instruction for a single cycle; returns at the negedge after the start edge
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      start_i  = 1'b1;
      funct3_i = f;
      rs1_i    = a;
      rs2_i    = b;
      rd_i     = rd;
      @(negedge clk);
      start_i  = 1'b0;
   endtask

   // Cycles from the start edge until done_o is seen (1 = cycle after start edge)
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (done_o !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b1; flush_i = 1'b0;
      funct3_i = 3'b000; rs1_i = 32'd1; rs2_i = 32'd1; rd_i = 5'd1;
      repeat (2) @(negedge clk);
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want %h", result_o, 32'h0); end
      checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      start_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      $display("reset: outputs idle");
   endtask

   task automatic test_mul();
      int cyc;
      int stall_bad;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFFFFFD; rd_i = 5'd11;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL mul_stall_start: got %b want 1", stall_o); end
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1; stall_bad = 0;
      while (done_o !== 1'b1 && cyc < 60) begin
         if (stall_o !== 1'b1 || busy_o !== 1'b1) stall_bad++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", cyc); end
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL mul_stall_calc: got %0d low cycles want 0", stall_bad); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mul_stall_done: got %b want 0", stall_o); end
      checks++; if (result_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result: got %h want FFFFFFEB", result_o); end
      checks++; if (rd_o !== 5'd11) begin errors++; $display("FAIL mul_rd: got %0d want 11", rd_o); end
      @(negedge clk);
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mul_idle: busy got %b want 0", busy_o); end
      $display("MUL 7 x FFFFFFFD -> %h rd=%0d in %0d cycles", result_o, rd_o, cyc);
   endtask

   task automatic test_calc_ops();
      logic [2:0]  f   [8] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111, 3'b000};
      logic [31:0] a   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'h00012345};
      logic [31:0] b   [8] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'd2,
                               32'd2, 32'd7, 32'd7, 32'h00010000};
      logic [31:0] exp [8] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'h23450000};
      int cyc;
      for (int i = 0; i < 8; i++) begin
         issue(f[i], a[i], b[i], 5'(i + 2));
         wait_done(cyc);
         checks++; if (cyc !== 33) begin errors++; $display("FAIL op%0d_latency: got %0d want 33", i, cyc); end
         checks++; if (result_o !== exp[i]) begin errors++; $display("FAIL op%0d_result f3=%0d: got %h want %h", i, f[i], result_o, exp[i]); end
         checks++; if (rd_o !== 5'(i + 2)) begin errors++; $display("FAIL op%0d_rd: got %0d want %0d", i, rd_o, i + 2); end
         $display("f3=%0d %h op %h -> %h rd=%0d in %0d cycles", f[i], a[i], b[i], result_o, rd_o, cyc);
      end
   endtask

   task automatic test_special();
      logic [2:0]  f   [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
      logic [31:0] a   [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
      logic [31:0] b   [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
      logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
      int cyc;
      for (int i = 0; i < 5; i++) begin
         issue(f[i], a[i], b[i], 5'(i + 20));
         wait_done(cyc);
         checks++; if (cyc !== 1) begin errors++; $display("FAIL special%0d_latency: got %0d want 1", i, cyc); end
         checks++; if (result_o !== exp[i]) begin errors++; $display("FAIL special%0d_result: got %h want %h", i, result_o, exp[i]); end
         checks++; if (rd_o !== 5'(i + 20)) begin errors++; $display("FAIL special%0d_rd: got %0d want %0d", i, rd_o, i + 20); end
         $display("special f3=%0d %h op %h -> %h in %0d cycles", f[i], a[i], b[i], result_o, cyc);
      end
   endtask

   task automatic test_flush();
      int cyc;
      int ndone;
      issue(3'b101, 32'd100, 32'd7, 5'd8);
      wait_done(cyc);
      checks++; if (result_o !== 32'd14) begin errors++; $display("FAIL flush_pre_result: got %h want 0000000e", result_o); end
      issue(3'b000, 32'd5, 32'd6, 5'd9);
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_o); end
      checks++; if (result_o !== 32'd14) begin errors++; $display("FAIL flush_result_held: got %h want 0000000e", result_o); end
      checks++; if (rd_o !== 5'd8) begin errors++; $display("FAIL flush_rd_held: got %0d want 8", rd_o); end
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (done_o === 1'b1) ndone++;
         @(negedge clk);
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
      $display("flush in CALC cycle 10: result held %h", result_o);
      issue(3'b000, 32'd3, 32'd4, 5'd10);
      wait_done(cyc);
      checks++; if (result_o !== 32'd12) begin errors++; $display("FAIL flush_next_mul: got %h want 0000000c", result_o); end
      checks++; if (cyc !== 33) begin errors++; $display("FAIL flush_next_latency: got %0d want 33", cyc); end
      $display("MUL 3 x 4 -> %h in %0d cycles", result_o, cyc);
   endtask

   task automatic test_rst_mid();
      int cyc;
      issue(3'b000, 32'd7, 32'd7, 5'd12);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h want 0", result_o); end
      checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL rstmid_rd: got %0d want 0", rd_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", stall_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done_o); end
      @(negedge clk);
      rst = 1'b0;
      issue(3'b100, 32'd9, 32'd3, 5'd13);
      wait_done(cyc);
      checks++; if (result_o !== 32'd3) begin errors++; $display("FAIL rstmid_div: got %h want 00000003", result_o); end
      checks++; if (cyc !== 33) begin errors++; $display("FAIL rstmid_latency: got %0d want 33", cyc); end
      $display("reset mid-CALC, then DIV 9/3 -> %h in %0d cycles", result_o, cyc);
   endtask

   task automatic test_busy_ignore();
      int ndone;
      logic [31:0] res;
      logic [4:0]  rdv;
      issue(3'b101, 32'd100, 32'd7, 5'd6);
      repeat (4) @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd1;
      @(negedge clk);
      start_i = 1'b0;
      ndone = 0; res = '0; rdv = '0;
      for (int i = 0; i < 80; i++) begin
         if (done_o === 1'b1) begin
            ndone++;
            res = result_o;
            rdv = rd_o;
         end
         @(negedge clk);
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_single_done: got %0d want 1", ndone); end
      checks++; if (res !== 32'd14) begin errors++; $display("FAIL busy_result: got %h want 0000000e", res); end
      checks++; if (rdv !== 5'd6) begin errors++; $display("FAIL busy_rd: got %0d want 6", rdv); end
      $display("start while busy ignored: %0d done pulse(s), result %h rd=%0d", ndone, res, rdv);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
      test_reset();
      test_mul();
      test_calc_ops();
      test_special();
      test_flush();
      test_rst_mid();
      test_busy_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands, funct3 and rd that the ID/EX pipeline register presents, and holds the pipeline through `stall_o` while it computes. It hands one 32-bit result plus its destination register back to the EX/MEM path with a single-cycle `done_o` pulse. It is a radix-2 shift-add multiplier and restoring divider sharing one datapath and one cycle counter.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 is supported)
- `ITER`, 32, number of CALC iterations (must equal `XLEN`)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start_i`  in  1  ID/EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001)
- `funct3_i`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_i`  in  32  operand A (rdata1 from ID/EX)
- `rs2_i`  in  32  operand B (rdata2 from ID/EX)
- `rd_i`  in  5  destination register
- `flush_i`  in  1  abort the current operation (branch taken or exception)
- `stall_o`  out  1  hold PC, IF/ID and ID/EX
- `busy_o`  out  1  state is not IDLE
- `done_o`  out  1  result valid; one-cycle pulse
- `result_o`  out  32  result
- `rd_o`  out  5  destination register for `result_o`

## Operation
- States: IDLE, CALC, DONE.
- **IDLE → CALC** on `start_i && !flush_i`.
  - Latch funct3 and rd.
  - Latch operand magnitudes and the sign flags selected by funct3:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both operands signed.
    - MUL, MULHU, DIVU, REMU: unsigned.
  - Clear the 6-bit counter.
- **IDLE → DONE** directly when the operation is a special case. The result is decided at start:
  - Divide by zero (rs2 == 0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- **CALC**: one iteration per cycle; the counter increments each cycle. Leave CALC when counter == ITER−1.
  - Multiply: 64-bit accumulator, add-and-shift on the multiplier LSB.
  - Divide: restoring; shift the remainder left, subtract the divisor, set the quotient bit if the result is non-negative.
- **CALC → DONE**: apply the sign fix while registering `result_o`.
  - Product: negated if exactly one operand sign flag is set.
  - Quotient: negated if the signs differ.
  - Remainder: takes the dividend's sign.
  - MUL selects product[31:0]; MULH, MULHSU and MULHU select product[63:32].
- **DONE → IDLE** unconditionally.
- `start_i` is ignored while `busy_o` is high.
- `flush_i` in CALC or DONE: next state IDLE. No `done_o` pulse; `result_o`/`rd_o` are not updated.
- `flush_i` together with `start_i` in IDLE: flush wins and nothing starts.
- `stall_o` = (IDLE && `start_i` && !`flush_i`) || CALC. It is combinational and low in DONE so the pipeline advances exactly when the result is presented.
- `result_o`/`rd_o` hold their value until the next DONE.

## Timing
- Reset (asynchronous, while `rst` high): state IDLE, counter 0.
  - `result_o` = 0, `rd_o` = 0, `done_o` = 0, `busy_o` = 0.
  - `stall_o` forced to 0.
- Normal latency: `start_i` sampled at edge E0.
  - CALC spans the cycles after E0..E32.
  - `done_o` = 1 in the cycle after E32, i.e. 33 cycles after the start edge.
  - IDLE after E33.
- Special-case latency: `done_o` = 1 in the cycle after E0.
- Back-to-back: a new `start_i` is accepted no earlier than the cycle after DONE.
- Reset asserted mid-CALC: outputs go to their reset values immediately. After release the unit starts from IDLE.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD -> `result_o`=0xFFFFFFEB, `rd_o`=rd, `done_o` pulse 33 cycles after start. `stall_o` high from the start cycle through CALC, low in DONE.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with `done_o` one cycle after start and no CALC cycles. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Assert `flush_i` in the 10th CALC cycle -> no `done_o`, `busy_o` low next cycle, `result_o` unchanged. A following MUL 3×4 -> 12.
- Assert `rst` mid-CALC -> all outputs 0 immediately. After release, DIV 9/3 -> 3 with normal latency. `start_i` pulsed while busy is ignored (single `done_o`).
